lsu_unit: RTL and testbench
===========================

# lsu_unit

Load/store unit that sits directly downstream of the execute stage of `riscv_top`. It turns the core's memory request into a registered, handshaked data-memory bus transaction. The core supplies `mem_read`/`mem_write` qualified by `alu_result` as the address and `reg_data2` as store data. The unit performs byte-lane steering, load extraction and extension, misalignment and illegal-width detection, and a bus timeout, and asserts `stall` so the core holds its PC until the access completes.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles in BUSY without `mem_ack` before an error response (must be ≥1).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: core access request (`mem_read | mem_write`).
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: access width and sign (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-aligned.
- `req_ready` out 1: unit is IDLE and can accept a request.
- `stall` out 1: combinational `req_valid & ~rsp_valid`; the core freezes its PC while this is high.
- `rsp_valid` out 1: one-cycle completion pulse for loads and stores.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: valid with `rsp_valid`; indicates misaligned, illegal funct3, or timeout.
- `mem_req` out 1: bus request; held until acked.
- `mem_we` out 1: bus write enable.
- `mem_addr` out 32: word address, `{req_addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: bus completion; sampled only while `mem_req`=1.
- `mem_rdata` in 32: read word, valid in the cycle `mem_ack`=1.

## Operation
- FSM states:
  - IDLE: `req_ready`=1. Transitions on `req_valid`:
    - to BUSY for a legal request;
    - to RESP with err for a misaligned or illegal request, with no bus access.
  - BUSY: `mem_req`=1. On `mem_ack`, go to RESP; when the timeout counter reaches `TIMEOUT_CYCLES`, go to RESP with err.
  - RESP: `rsp_valid`=1, `req_ready`=0. Always returns to IDLE on the next cycle.
- Misaligned: halfword with `addr[0]`=1; word with `addr[1:0]`≠0.
- Illegal funct3: loads with 3, 6, or 7; stores with 3–7.
- Store lanes:
  - SB: `be`=1<<`addr[1:0]`, `wdata`={4{b}}.
  - SH: `be`=`addr[1]` ? 4'b1100 : 4'b0011, `wdata`={2{h}}.
  - SW: `be`=4'b1111.
- Loads: `be` follows the same rule as stores. The captured word is shifted right by 8·`addr[1:0]`, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- Request fields (`we`, `funct3`, `addr[1:0]`, `wdata`) are registered at acceptance. Bus outputs come only from these registers.
- `mem_ack` outside BUSY is ignored.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`, `rsp_valid`, `rsp_rdata`, `rsp_err`, and the timeout counter are all 0.
- Accept in cycle 0 (IDLE and `req_valid`). `mem_req` rises in cycle 1.
- `mem_addr`, `mem_be`, `mem_we`, `mem_wdata` are stable while `mem_req`=1.
- `mem_ack` in cycle k gives `rsp_valid` in cycle k+1, with `rsp_rdata` registered from `mem_rdata` at cycle k. `mem_req` is 0 in cycle k+1.
- Zero-wait bus (ack in cycle 1): response in cycle 2. Minimum access is 3 cycles including the accept cycle.
- Error without bus access: response in cycle 1.
- Timeout: the counter increments each BUSY cycle without ack. When the count equals `TIMEOUT_CYCLES`, the next cycle is RESP with `rsp_err`=1 and `mem_req`=0.
  - If ack and timeout coincide, ack wins and `rsp_err`=0.
- The core holds its request stable while stalled. In the RESP cycle, `stall`=0 and the core advances.
  - A new `req_valid` in RESP is not accepted until the following IDLE cycle.
- Reset mid-access: `mem_req` drops at the reset edge, no response is produced, and a late `mem_ack` is ignored.

## Structure
- Shared package `riscv_pkg`:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - `lsu_state_t` enum {IDLE, BUSY, RESP}.
- Sub-module `lsu_align`: purely combinational.
  - Store direction: funct3 and `addr[1:0]` in, `be`/`wdata`/`misaligned`/`illegal` out.
  - Load direction: `rdata` and offset in, extended data out.
  - It is instantiated once and shared by both directions.
- The timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide.

## Test plan
- SW to 0x100 with data 0xDEADBEEF, ack in cycle 1 → `mem_addr`=0x100, `be`=4'hF; `rsp_valid` in cycle 2 with err=0.
- LB from 0x103 where the word is 0x80FF_1234 → `be`=4'b1000, `rsp_rdata`=0xFFFF_FF80. LBU from the same address → 0x0000_0080.
- SH to 0x202 with data 0x0000_ABCD → `be`=4'b1100, `mem_wdata`=0xABCD_ABCD. LH from 0x201 → `rsp_err`=1 in cycle 1, and `mem_req` never asserts.
- Ack delayed 5 cycles → `mem_req` held with stable address and byte enables, `stall`=1 throughout; `rsp_valid` in cycle 7.
- No ack with `TIMEOUT_CYCLES`=4 → err response in cycle 6, and `mem_req` low from cycle 6. A separate run with ack arriving exactly on the timeout cycle → err=0.
- Reset asserted in BUSY → all outputs 0 next cycle; a late ack yields no `rsp_valid`, and the next LW is accepted normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg : shared load/store funct3 codes and LSU state encoding
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align : combinational byte-lane steering, access checks, load extension
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_align
  import riscv_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic        misaligned,
  output logic        illegal,
  output logic [31:0] rdata_out
);

  logic [31:0] w_shifted;

  assign w_shifted = rdata_in >> {offset, 3'b000};

  always_comb begin
    be         = 4'b0000;
    wdata_out  = 32'd0;
    misaligned = 1'b0;
    // funct3[1:0] gives the access size for both signed and unsigned loads
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << offset;
        wdata_out = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        be         = offset[1] ? 4'b1100 : 4'b0011;
        wdata_out  = {2{wdata_in[15:0]}};
        misaligned = offset[0];
      end
      2'b10: begin
        be         = 4'b1111;
        wdata_out  = wdata_in;
        misaligned = |offset;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (we) illegal = funct3[2] | (funct3[1:0] == 2'b11);
    else    illegal = (funct3[1:0] == 2'b11) | (funct3 == 3'd6);
  end

  always_comb begin
    rdata_out = 32'd0;
    case (funct3)
      F3_B:    rdata_out = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    rdata_out = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    rdata_out = w_shifted;
      F3_BU:   rdata_out = {24'd0, w_shifted[7:0]};
      F3_HU:   rdata_out = {16'd0, w_shifted[15:0]};
      default: rdata_out = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_unit.sv
// ---------------------------------------------------------------------------
// lsu_unit : registered, handshaked data-memory access with bus timeout
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int                CW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]     C_TMO_MAX = CW'(TIMEOUT_CYCLES);

  lsu_state_t    r_state;
  logic [CW-1:0] r_tmo_cnt;
  logic          r_we;
  logic [2:0]    r_funct3;
  logic [1:0]    r_off;

  logic          w_idle;
  logic          w_al_we;
  logic [2:0]    w_al_funct3;
  logic [1:0]    w_al_off;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_misaligned;
  logic          w_illegal;
  logic [31:0]   w_load_data;

  // One aligner: fed from the live request while idle, from the captured
  // fields while the access is outstanding.
  assign w_idle      = (r_state == IDLE);
  assign w_al_we     = w_idle ? req_we        : r_we;
  assign w_al_funct3 = w_idle ? req_funct3    : r_funct3;
  assign w_al_off    = w_idle ? req_addr[1:0] : r_off;

  lsu_align u_align (
    .we         (w_al_we),
    .funct3     (w_al_funct3),
    .offset     (w_al_off),
    .wdata_in   (req_wdata),
    .rdata_in   (mem_rdata),
    .be         (w_be),
    .wdata_out  (w_wdata),
    .misaligned (w_misaligned),
    .illegal    (w_illegal),
    .rdata_out  (w_load_data)
  );

  assign req_ready = w_idle;
  assign stall     = req_valid & ~rsp_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_tmo_cnt <= '0;
      r_we      <= 1'b0;
      r_funct3  <= 3'd0;
      r_off     <= 2'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tmo_cnt <= '0;
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_off    <= req_addr[1:0];
            if (w_misaligned || w_illegal) begin
              r_state   <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
            end else begin
              r_state   <= BUSY;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= w_be;
              mem_wdata <= w_wdata;
            end
          end
        end
        BUSY: begin
          // An ack in the final timeout cycle still completes normally
          if (mem_ack) begin
            r_state   <= RESP;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= r_we ? 32'd0 : w_load_data;
          end else if (r_tmo_cnt == C_TMO_MAX) begin
            r_state   <= RESP;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'd0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + CW'(1);
          end
        end
        RESP: begin
          r_state   <= IDLE;
          r_tmo_cnt <= '0;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'd0;
        end
        default: begin
          r_state <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_unit.sv
// ---------------------------------------------------------------------------
// tb_lsu_unit : scoreboard bench for lsu_unit with a behavioural access model
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lsu_unit;

  localparam int TMO = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, stall, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  lsu_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .stall(stall),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic err; logic [31:0] rdata; } exp_t;
  exp_t sbq[$];

  int n_pass = 0;
  int n_total = 0;

  logic        eb_active = 1'b0;
  logic        eb_we;
  logic [31:0] eb_addr, eb_wdata, bus_word;
  logic [3:0]  eb_be;
  int          ack_at = -100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic flag(input string name);
    n_total++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: size from funct3, lanes from offset, load = bytes picked out of the word
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] word,
                                output logic early, output logic [3:0] be,
                                output logic [31:0] bwd, output logic [31:0] ld);
    int size, off;
    logic legal;
    logic [31:0] v, mask;
    off   = int'(addr[1:0]);
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = legal ? (1 << f3[1:0]) : 1;
    early = !legal || (off % size != 0);
    be = 4'b0000;
    bwd = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + size) be[i] = 1'b1;
      bwd[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    v = word >> (8 * off);
    if (size < 4) begin
      mask = (32'd1 << (8 * size)) - 32'd1;
      v = v & mask;
      if (f3 < 3'd4 && v[8*size-1]) v = v | ~mask;
    end
    ld = we ? 32'd0 : v;
  endfunction

  // Bus responder: acks on the planned cycle, otherwise random stray acks while idle
  initial begin
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (cyc == ack_at) begin
        mem_ack = 1'b1; mem_rdata = bus_word;
      end else if (!mem_req && $urandom_range(0, 3) == 0) begin
        mem_ack = 1'b1; mem_rdata = $urandom;
      end else begin
        mem_ack = 1'b0; mem_rdata = $urandom;
      end
    end
  end

  // Monitor: response scoreboard and bus-field checks
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (sbq.size() == 0) flag("unexpected_rsp_valid");
        else begin
          e = sbq.pop_front();
          chk("rsp_cycle", cyc, e.due);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          chk("rsp_rdata", rsp_rdata, e.rdata);
        end
      end
      if (mem_req) begin
        if (!eb_active) flag("unexpected_mem_req");
        else begin
          chk("mem_addr", mem_addr, eb_addr);
          chk("mem_be", {28'd0, mem_be}, {28'd0, eb_be});
          chk("mem_we", {31'd0, mem_we}, {31'd0, eb_we});
          chk("mem_wdata", mem_wdata, eb_wdata);
        end
      end
    end
  end

  // d = ack delay after cycle 1 (d > TMO means the bus never answers in time)
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int d, input logic [31:0] word);
    logic early, got;
    logic [3:0] be;
    logic [31:0] bwd, ld;
    int lat, start;
    exp_t e;
    model(we, f3, addr, wd, word, early, be, bwd, ld);
    @(posedge clk); #1;
    start = cyc;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    eb_active = !early; eb_we = we; eb_addr = {addr[31:2], 2'b00};
    eb_be = be; eb_wdata = bwd; bus_word = word;
    if (early) begin
      lat = 1; e.err = 1'b1; e.rdata = 32'd0; ack_at = -100;
    end else if (d <= TMO) begin
      lat = 2 + d; e.err = 1'b0; e.rdata = ld; ack_at = start + 1 + d;
    end else begin
      lat = TMO + 2; e.err = 1'b1; e.rdata = 32'd0; ack_at = -100;
    end
    e.due = start + lat;
    sbq.push_back(e);
    got = 1'b0;
    for (int n = 0; n < lat + 4 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
      else begin
        chk("stall_pending", {31'd0, stall}, 32'd1);
        chk("mem_req_level", {31'd0, mem_req}, {31'd0, (n >= 1 && !early)});
      end
    end
    if (!got) flag("rsp_wait_expired");
    else begin
      chk("stall_resp", {31'd0, stall}, 32'd0);
      chk("mem_req_resp", {31'd0, mem_req}, 32'd0);
      chk("ready_resp", {31'd0, req_ready}, 32'd0);
    end
  endtask

  task automatic gap(input int k);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk("ready_idle", {31'd0, req_ready}, 32'd1);
      chk("stall_idle", {31'd0, stall}, 32'd0);
    end
  endtask

  task automatic reset_mid_access();
    logic early;
    logic [3:0] be;
    logic [31:0] bwd, ld;
    model(1'b0, 3'd2, 32'h40, 32'd0, 32'h0, early, be, bwd, ld);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'd0;
    eb_active = 1'b1; eb_we = 1'b0; eb_addr = 32'h40; eb_be = be; eb_wdata = bwd;
    ack_at = -100;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; eb_active = 1'b0; ack_at = cyc + 1;
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("late_ack_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    flag("global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    logic we;
    logic [2:0] f3;
    int d, sel;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset_mem_be", {28'd0, mem_be}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1 reset = 1'b0;

    access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 32'h0);
    access(1'b0, 3'd0, 32'h103, 32'h0, 0, 32'h80FF1234);
    access(1'b0, 3'd4, 32'h103, 32'h0, 0, 32'h80FF1234);
    access(1'b1, 3'd1, 32'h202, 32'h0000ABCD, 1, 32'h0);
    access(1'b0, 3'd1, 32'h201, 32'h0, 0, 32'h0);
    gap(2);
    access(1'b0, 3'd2, 32'h300, 32'h0, 5, 32'h12345678);
    access(1'b0, 3'd2, 32'h304, 32'h0, 99, 32'h0);
    access(1'b0, 3'd5, 32'h306, 32'h0, TMO, 32'h8001_7FFF);
    access(1'b1, 3'd3, 32'h400, 32'h1, 0, 32'h0);
    access(1'b0, 3'd7, 32'h400, 32'h0, 0, 32'h0);
    access(1'b1, 3'd4, 32'h400, 32'h1, 0, 32'h0);
    reset_mid_access();
    access(1'b0, 3'd2, 32'h500, 32'h0, 0, 32'hCAFEF00D);

    for (int t = 0; t < 300; t++) begin
      we  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel < 8) f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
      else         f3 = 3'($urandom_range(0, 7));
      if (!we && f3 == 3'd3) f3 = 3'd5;
      sel = $urandom_range(0, 9);
      if (sel < 6)       d = $urandom_range(0, 3);
      else if (sel == 6) d = TMO;
      else if (sel == 7) d = TMO + 1;
      else if (sel == 8) d = 99;
      else               d = $urandom_range(0, TMO);
      access(we, f3, $urandom, $urandom, d, $urandom);
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
    end
    gap(3);
    if (sbq.size() != 0) flag("scoreboard_not_empty");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
